mips_mem_sequencer: RTL and testbench
=====================================

# mips_mem_sequencer

Multi-cycle sequencer that lets the Harvard MIPS core run against a single shared Avalon-style memory port with wait-request. Each instruction is processed in four steps:
- fetch the instruction and latch it;
- let the core decode the latched word;
- perform the core's data access, if it requested one;
- pulse the core's `clk_enable` for exactly one cycle to commit.

The block sits between the core's `instr_*`/`data_*` ports and the unified memory bus, and it owns the core's `clk_enable`.

## Interface
Parameters:
- `MAX_WAIT`, default 0. Maximum cycles to wait on `mem_waitrequest` per access; 0 means unlimited.

Ports:
- `clk` input 1. Single clock; all state changes on the rising edge.
- `reset` input 1. Asynchronous, active-low reset.
- `cpu_active` input 1. The core's `active` output.
- `cpu_clk_enable` output 1. Clock enable to the core.
- `cpu_instr_address` input 32. Core fetch address (pc).
- `cpu_instr_readdata` output 32. Latched instruction word presented to the core.
- `cpu_data_address` input 32. Core data address.
- `cpu_data_read` input 1. Core load request.
- `cpu_data_write` input 1. Core store request.
- `cpu_data_writedata` input 32. Core store data.
- `cpu_data_readdata` output 32. Latched load data presented to the core.
- `mem_address` output 32. Memory byte address.
- `mem_read` output 1. Memory read strobe.
- `mem_write` output 1. Memory write strobe.
- `mem_writedata` output 32. Memory write data.
- `mem_readdata` input 32. Memory read data.
- `mem_waitrequest` input 1. Memory stall; an access completes on the first edge where this is low.
- `fault` output 1. Sticky; set when `MAX_WAIT` is exceeded.

## Operation
States:
- **IDLE**: no memory access, `cpu_clk_enable`=0. Go to FETCH when `cpu_active`=1 and `fault`=0.
- **FETCH**: `mem_read`=1, `mem_address`=`cpu_instr_address` (sampled on entry, held for the whole access). On the first edge with `mem_waitrequest`=0: latch `mem_readdata` into the instruction register, then go to DECODE.
- **DECODE**: one cycle with no memory access. The core decodes the held instruction. Sample `cpu_data_read`, `cpu_data_write`, `cpu_data_address` and `cpu_data_writedata` into internal registers.
  - If read or write was sampled → DATA.
  - Otherwise → COMMIT.
- **DATA**: drive the latched request. Load: `mem_read`=1. Store: `mem_write`=1 with `mem_writedata`.
  - Address and data are held stable until the first edge with `mem_waitrequest`=0.
  - On that edge a load latches `mem_readdata` into the load-data register.
  - Then go to COMMIT.
  - If read and write were both sampled, the read takes precedence and the write is dropped.
- **COMMIT**: `cpu_clk_enable`=1 for exactly this one cycle. Next state:
  - FETCH if `cpu_active`=1 on this cycle;
  - HALT otherwise.
- **HALT**: entered when the core has executed its stop instruction and dropped `active`. Stays idle with `cpu_clk_enable`=0. Returns to IDLE only when `cpu_active` is seen low then high again (core re-reset).

Output and register rules:
- `cpu_instr_readdata` and `cpu_data_readdata` are registers. Each changes only on its latching edge and holds its value between instructions.
- `mem_read` and `mem_write` are never both 1, and both are 0 outside FETCH and DATA.
- Wait counter:
  - Counts cycles with `mem_waitrequest`=1 in FETCH or DATA; cleared on each new access.
  - If `MAX_WAIT`≠0 and the count reaches `MAX_WAIT`: set `fault`, deassert strobes and go to IDLE.
  - `fault` is cleared only by `reset`.

## Timing
Reset:
- While `reset`=0, asynchronously: state=IDLE, all strobes 0, `cpu_clk_enable`=0, `fault`=0, `mem_address`=0, `mem_writedata`=0, both readdata registers=0.
- An access in progress is abandoned immediately. A pending store is not retried.

Latency with zero-wait memory:
- Non-memory instruction: FETCH, DECODE, COMMIT = 3 cycles.
- Load or store: FETCH, DECODE, DATA, COMMIT = 4 cycles.
- Each wait-request cycle adds one cycle to FETCH or DATA.

Ordering:
- The core's pc advances only at the COMMIT edge, so `cpu_instr_address` is stable from FETCH entry through COMMIT.
- A store is written to memory before the committing edge.

Boundary cases:
- `cpu_active` falling during FETCH, DECODE or DATA: the current instruction still completes through COMMIT, then the block goes to HALT.
- A write is accepted by memory only on an edge with `mem_waitrequest`=0. `mem_write` is held until that edge.

## Test plan
- **ADDIU, zero-wait:** word 0x24420005 at 0. Expect `mem_read`=1 with address 0 for 1 cycle; `cpu_clk_enable` high on cycle 3; next fetch address 4.
- **LW with 2 wait cycles on the data access:** memory at 0x10 holds 0xDEADBEEF. Expect `cpu_data_readdata`=0xDEADBEEF before COMMIT; `cpu_clk_enable` pulses once, 6 cycles after fetch start.
- **SW:** expect `mem_write`=1 and `mem_read`=0. Address and writedata held stable through 3 wait cycles; exactly one accepted write.
- **Stop instruction (opcode 0x3F):** COMMIT, then `cpu_active`=0 → HALT. No further `mem_read` over 20 cycles.
- **Timeout, `MAX_WAIT`=4:** hold `mem_waitrequest`=1. Expect `fault`=1 after 4 wait cycles, strobes low, `cpu_clk_enable` never asserted.
- **Reset mid-DATA store:** `reset`=0 asynchronously. Expect `mem_write` to drop in the same cycle, all outputs at reset values, and restart from FETCH after release.

Source files
------------

// File: rtl/mips_mem_sequencer.sv
// rtl/mips_mem_sequencer.sv - multi-cycle fetch/decode/data/commit sequencer for a MIPS core on one shared memory port
module mips_mem_sequencer #(
  parameter int unsigned MAX_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_active,
  output logic        cpu_clk_enable,
  input  logic [31:0] cpu_instr_address,
  output logic [31:0] cpu_instr_readdata,
  input  logic [31:0] cpu_data_address,
  input  logic        cpu_data_read,
  input  logic        cpu_data_write,
  input  logic [31:0] cpu_data_writedata,
  output logic [31:0] cpu_data_readdata,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  output logic        fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_DATA,
    S_COMMIT,
    S_HALT
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] instr_q;
  logic [31:0] data_q;
  logic [31:0] wait_cnt;
  logic        rd_q;
  logic        wr_q;
  logic        seen_low;
  logic        fault_q;
  logic        in_access;
  logic        timeout;

  assign in_access = (state == S_FETCH) || (state == S_DATA);
  assign timeout   = (MAX_WAIT != 32'd0) && in_access && mem_waitrequest &&
                     ((wait_cnt + 32'd1) >= MAX_WAIT);

  // The core's pc only settles after the commit edge, so FETCH presents it
  // directly; it cannot move again until the next commit, so it is held.
  assign mem_address        = (state == S_FETCH) ? cpu_instr_address : addr_q;
  assign mem_read           = (state == S_FETCH) || ((state == S_DATA) && rd_q);
  assign mem_write          = (state == S_DATA) && wr_q && !rd_q;
  assign mem_writedata      = wdata_q;
  assign cpu_clk_enable     = (state == S_COMMIT);
  assign cpu_instr_readdata = instr_q;
  assign cpu_data_readdata  = data_q;
  assign fault              = fault_q;

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state selection for the fetch/decode/data/commit cycle.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (cpu_active && !fault_q) state_next = S_FETCH;
      end
      S_FETCH: begin
        if (timeout) state_next = S_IDLE;
        else if (!mem_waitrequest) state_next = S_DECODE;
      end
      S_DECODE: begin
        if (cpu_data_read || cpu_data_write) state_next = S_DATA;
        else state_next = S_COMMIT;
      end
      S_DATA: begin
        if (timeout) state_next = S_IDLE;
        else if (!mem_waitrequest) state_next = S_COMMIT;
      end
      S_COMMIT: begin
        state_next = cpu_active ? S_FETCH : S_HALT;
      end
      S_HALT: begin
        if (seen_low && cpu_active) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Request capture, read-data latching, wait counting and sticky fault.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      instr_q  <= 32'd0;
      data_q   <= 32'd0;
      wait_cnt <= 32'd0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      seen_low <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      wait_cnt <= (in_access && mem_waitrequest) ? wait_cnt + 32'd1 : 32'd0;
      seen_low <= (state == S_HALT) && (seen_low || !cpu_active);
      if (timeout) fault_q <= 1'b1;
      if ((state == S_FETCH) && !mem_waitrequest) instr_q <= mem_readdata;
      if (state == S_DECODE) begin
        rd_q    <= cpu_data_read;
        wr_q    <= cpu_data_write;
        wdata_q <= cpu_data_writedata;
        if (cpu_data_read || cpu_data_write) addr_q <= cpu_data_address;
      end
      if ((state == S_DATA) && rd_q && !mem_waitrequest) data_q <= mem_readdata;
    end
  end

endmodule

// File: tb/tb_mips_mem_sequencer.sv
// tb/tb_mips_mem_sequencer.sv - self-checking bench for mips_mem_sequencer
module tb_mips_mem_sequencer;

  localparam logic [31:0] STOP = 32'hFC000000;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_active;
  logic [31:0] cpu_instr_address;
  logic [31:0] cpu_data_address;
  logic        cpu_data_read;
  logic        cpu_data_write;
  logic [31:0] cpu_data_writedata;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest;
  logic        t_waitrequest;

  logic        cpu_clk_enable;
  logic [31:0] cpu_instr_readdata;
  logic [31:0] cpu_data_readdata;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic        fault;

  logic        t_clk_enable;
  logic [31:0] t_instr_readdata;
  logic [31:0] t_data_readdata;
  logic [31:0] t_mem_address;
  logic        t_mem_read;
  logic        t_mem_write;
  logic [31:0] t_mem_writedata;
  logic        t_fault;

  always #5 clk = ~clk;

  mips_mem_sequencer dut (
    .clk(clk), .reset(reset), .cpu_active(cpu_active), .cpu_clk_enable(cpu_clk_enable),
    .cpu_instr_address(cpu_instr_address), .cpu_instr_readdata(cpu_instr_readdata),
    .cpu_data_address(cpu_data_address), .cpu_data_read(cpu_data_read),
    .cpu_data_write(cpu_data_write), .cpu_data_writedata(cpu_data_writedata),
    .cpu_data_readdata(cpu_data_readdata), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_waitrequest(mem_waitrequest), .fault(fault)
  );

  mips_mem_sequencer #(.MAX_WAIT(4)) dut_to (
    .clk(clk), .reset(reset), .cpu_active(cpu_active), .cpu_clk_enable(t_clk_enable),
    .cpu_instr_address(cpu_instr_address), .cpu_instr_readdata(t_instr_readdata),
    .cpu_data_address(cpu_data_address), .cpu_data_read(cpu_data_read),
    .cpu_data_write(cpu_data_write), .cpu_data_writedata(cpu_data_writedata),
    .cpu_data_readdata(t_data_readdata), .mem_address(t_mem_address), .mem_read(t_mem_read),
    .mem_write(t_mem_write), .mem_writedata(t_mem_writedata), .mem_readdata(mem_readdata),
    .mem_waitrequest(t_waitrequest), .fault(t_fault)
  );

  typedef struct {
    bit          fetch;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  typedef struct {
    logic [31:0] instr;
    int          wf;
    int          wd;
    int          lat;
    int          writes;
    logic [31:0] drd;
  } vec_t;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem     [64];
  logic [31:0] exp_mem [64];
  int          wsched  [256];
  txn_t        exp_q[$];
  logic [31:0] exp_instr[$];
  int          exp_lat[$];

  logic [31:0] pc;
  logic [31:0] ir_exp;
  logic [31:0] dr_exp;
  logic [31:0] a_addr;
  logic [31:0] a_wd;
  bit          a_wr;
  bit          in_acc;
  bit          commit_pending;
  bit          stop_done;
  bit          prev_ce;
  int          rem;
  int          acc_idx;
  int          instr_i;
  int          cyc;
  int          fetch_start;
  int          quiet;
  int          n_writes;
  int          lat0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ctl"}, {27'd0, cpu_clk_enable, mem_read, mem_write, fault, t_fault}, 32'd0);
    chk({tag, "_addr"}, mem_address, 32'd0);
    chk({tag, "_wdata"}, mem_writedata, 32'd0);
    chk({tag, "_ir"}, cpu_instr_readdata, 32'd0);
    chk({tag, "_dr"}, cpu_data_readdata, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cpu_active = 1'b1;
    cpu_instr_address = 32'd0;
    cpu_data_address = 32'd0;
    cpu_data_read = 1'b0;
    cpu_data_write = 1'b0;
    cpu_data_writedata = 32'd0;
    mem_readdata = 32'd0;
    mem_waitrequest = 1'b0;
    t_waitrequest = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_reset_vals("rst");
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic model_reset();
    pc = 32'd0; ir_exp = 32'd0; dr_exp = 32'd0;
    in_acc = 0; commit_pending = 0; stop_done = 0; prev_ce = 0;
    rem = 0; acc_idx = 0; instr_i = 0; cyc = 0; fetch_start = 0;
    quiet = 0; n_writes = 0; lat0 = -1;
  endtask

  // Walk the program instruction by instruction to list the expected bus
  // transactions, per-instruction latencies and the final memory image.
  task automatic build_expect();
    logic [31:0] mm [64];
    logic [31:0] p;
    logic [31:0] w;
    logic [31:0] da;
    logic [5:0]  op;
    int a;
    int lat;
    for (int i = 0; i < 64; i++) mm[i] = mem[i];
    exp_q.delete(); exp_instr.delete(); exp_lat.delete();
    p = 32'd0;
    a = 0;
    for (int n = 0; n < 64; n++) begin
      w = mm[p[7:2]];
      op = w[31:26];
      da = {16'h0, w[15:0]};
      exp_instr.push_back(w);
      exp_q.push_back('{fetch: 1, wr: 0, addr: p, data: 32'd0});
      lat = 3 + wsched[a];
      a++;
      if (op == 6'h23 || op == 6'h3E) begin
        exp_q.push_back('{fetch: 0, wr: 0, addr: da, data: 32'd0});
        lat += 1 + wsched[a];
        a++;
      end else if (op == 6'h2B) begin
        exp_q.push_back('{fetch: 0, wr: 1, addr: da, data: {16'hC0DE, w[15:0]}});
        mm[da[7:2]] = {16'hC0DE, w[15:0]};
        lat += 1 + wsched[a];
        a++;
      end
      exp_lat.push_back(lat);
      if (op == 6'h3F) break;
      p += 32'd4;
    end
    for (int i = 0; i < 64; i++) exp_mem[i] = mm[i];
  endtask

  // One clock of the core model and the wait-state memory model.
  task automatic step();
    logic [5:0]  op;
    logic [31:0] rdata;
    int idx;
    @(posedge clk);
    #1;
    cyc++;
    if (commit_pending) begin
      pc += 32'd4;
      commit_pending = 0;
    end
    chk("ir_hold", cpu_instr_readdata, ir_exp);
    chk("dr_hold", cpu_data_readdata, dr_exp);
    op = cpu_instr_readdata[31:26];
    cpu_instr_address  = pc;
    cpu_active         = (op != 6'h3F);
    cpu_data_read      = (op == 6'h23) || (op == 6'h3E);
    cpu_data_write     = (op == 6'h2B) || (op == 6'h3E);
    cpu_data_address   = {16'h0, cpu_instr_readdata[15:0]};
    cpu_data_writedata = {16'hC0DE, cpu_instr_readdata[15:0]};
    #1;
    if (mem_read && mem_write) chk("one_strobe", 32'd1, 32'd0);
    if (mem_read || mem_write) begin
      if (!in_acc) begin
        in_acc = 1;
        rem = wsched[acc_idx];
        a_addr = mem_address;
        a_wr = mem_write;
        a_wd = mem_writedata;
        if (acc_idx < exp_q.size() && exp_q[acc_idx].fetch) fetch_start = cyc;
      end else begin
        chk("hold_addr", mem_address, a_addr);
        chk("hold_write", {31'd0, mem_write}, {31'd0, a_wr});
        if (a_wr) chk("hold_wdata", mem_writedata, a_wd);
      end
      if (rem > 0) begin
        rem--;
        mem_waitrequest = 1'b1;
        mem_readdata = $urandom;
      end else begin
        mem_waitrequest = 1'b0;
        idx = int'(mem_address[7:2]);
        if (mem_write) begin
          mem[idx] = mem_writedata;
          n_writes++;
          rdata = $urandom;
        end else begin
          rdata = mem[idx];
        end
        mem_readdata = rdata;
        if (acc_idx >= exp_q.size()) begin
          chk("extra_access", acc_idx, exp_q.size());
        end else begin
          chk("txn_write", {31'd0, mem_write}, {31'd0, exp_q[acc_idx].wr});
          chk("txn_addr", mem_address, exp_q[acc_idx].addr);
          if (exp_q[acc_idx].wr) chk("txn_wdata", mem_writedata, exp_q[acc_idx].data);
          if (exp_q[acc_idx].fetch) ir_exp = rdata;
          else if (!exp_q[acc_idx].wr) dr_exp = rdata;
        end
        acc_idx++;
        in_acc = 0;
      end
    end else begin
      mem_waitrequest = 1'($urandom_range(0, 1));
      mem_readdata = $urandom;
    end
    if (stop_done) begin
      quiet++;
      chk("halt_quiet", {30'd0, mem_read, mem_write}, 32'd0);
    end
    if (cpu_clk_enable) begin
      if (prev_ce) chk("single_pulse", 32'd1, 32'd0);
      if (instr_i >= exp_instr.size()) begin
        chk("extra_commit", instr_i, exp_instr.size());
      end else begin
        chk("commit_ir", cpu_instr_readdata, exp_instr[instr_i]);
        chk("commit_lat", cyc - fetch_start + 1, exp_lat[instr_i]);
        if (instr_i == 0) lat0 = cyc - fetch_start + 1;
        if (exp_instr[instr_i][31:26] == 6'h3F) stop_done = 1;
      end
      commit_pending = 1;
      instr_i++;
    end
    prev_ce = cpu_clk_enable;
  endtask

  task automatic run_prog(input int budget);
    int diffs;
    model_reset();
    build_expect();
    for (int k = 0; k < budget; k++) begin
      if (stop_done && quiet >= 20) break;
      step();
    end
    chk("run_finished", {31'd0, stop_done && quiet >= 20}, 32'd1);
    chk("commit_count", instr_i, exp_instr.size());
    chk("access_count", acc_idx, exp_q.size());
    diffs = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== exp_mem[i]) diffs++;
    chk("mem_image", diffs, 0);
  endtask

  vec_t vecs[6];

  initial begin
    int rd_cnt;
    int ce_cnt;
    int fault_at;
    int n;
    bit saw_write;

    vecs[0] = '{instr: 32'h24420005, wf: 0, wd: 0, lat: 3, writes: 0, drd: 32'h0};
    vecs[1] = '{instr: 32'h8C020010, wf: 0, wd: 2, lat: 6, writes: 0, drd: 32'hDEADBEEF};
    vecs[2] = '{instr: 32'hAC020014, wf: 0, wd: 3, lat: 7, writes: 1, drd: 32'h0};
    vecs[3] = '{instr: 32'h24420005, wf: 2, wd: 0, lat: 5, writes: 0, drd: 32'h0};
    vecs[4] = '{instr: 32'h8C020010, wf: 1, wd: 1, lat: 6, writes: 0, drd: 32'hDEADBEEF};
    vecs[5] = '{instr: 32'hF8000010, wf: 0, wd: 0, lat: 4, writes: 0, drd: 32'hDEADBEEF};

    cyc = 0;
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 64; i++) mem[i] = 32'd0;
      for (int i = 0; i < 256; i++) wsched[i] = 0;
      mem[0] = vecs[v].instr;
      mem[1] = STOP;
      mem[4] = 32'hDEADBEEF;
      mem[5] = 32'h11111111;
      wsched[0] = vecs[v].wf;
      wsched[1] = vecs[v].wd;
      do_reset();
      run_prog(200);
      chk($sformatf("vec%0d_lat", v), lat0, vecs[v].lat);
      chk($sformatf("vec%0d_writes", v), n_writes, vecs[v].writes);
      chk($sformatf("vec%0d_drd", v), cpu_data_readdata, vecs[v].drd);
    end

    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(3, 12);
      for (int i = 0; i < 32; i++) mem[i] = {6'h09, 26'($urandom)};
      for (int i = 32; i < 64; i++) mem[i] = $urandom;
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 3))
          0: mem[i] = {6'h23, 10'h0, 8'h0, 1'b1, 5'($urandom), 2'b00};
          1: mem[i] = {6'h2B, 10'h0, 8'h0, 1'b1, 5'($urandom), 2'b00};
          default: mem[i] = {6'h09, 26'($urandom)};
        endcase
      end
      mem[n] = STOP;
      for (int i = 0; i < 256; i++) wsched[i] = $urandom_range(0, 3);
      do_reset();
      run_prog(600);
    end

    do_reset();
    cpu_active = 1'b1;
    mem_waitrequest = 1'b1;
    t_waitrequest = 1'b1;
    rd_cnt = 0;
    ce_cnt = 0;
    fault_at = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #2;
      if (t_mem_read) rd_cnt++;
      if (t_clk_enable) ce_cnt++;
      if (t_fault && fault_at == 0) fault_at = c;
    end
    chk("to_read_cycles", rd_cnt, 4);
    chk("to_no_commit", ce_cnt, 0);
    chk("to_fault_cycle", fault_at, 5);
    chk("to_fault", {31'd0, t_fault}, 32'd1);
    chk("to_strobes", {30'd0, t_mem_read, t_mem_write}, 32'd0);
    chk("unlimited_no_fault", {31'd0, fault}, 32'd0);
    chk("unlimited_still_read", {31'd0, mem_read}, 32'd1);

    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    for (int i = 0; i < 256; i++) wsched[i] = 0;
    mem[0] = 32'hAC020014;
    mem[1] = STOP;
    wsched[1] = 10;
    do_reset();
    model_reset();
    build_expect();
    saw_write = 0;
    for (int k = 0; k < 20 && !saw_write; k++) begin
      step();
      if (mem_write) saw_write = 1;
    end
    chk("rst_store_started", {31'd0, saw_write}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_async_write", {31'd0, mem_write}, 32'd0);
    check_reset_vals("rst_async");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    run_prog(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
